// File: rtl/cpu_pkg.sv
// Shared constants for the serial arithmetic blocks: FSM state encoding
// used by the bit-serial subtractor control logic.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : cpu_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: difference and borrow-out of i_a - i_b - i_bi.
module full_subtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bi,
   output logic o_d,
   output logic o_bo
);

   always_comb begin
      o_d  = i_a ^ i_b ^ i_bi;
      o_bo = (~i_a & i_b) | (~(i_a ^ i_b) & i_bi);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: processes one bit per clock, LSB first,
// and presents the registered difference and borrow-out on completion.
module serial_subtractor
   import cpu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_d,
   output logic             o_bo
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic             fs_d;
   logic             fs_bo;

   full_subtractor u_full_subtractor (
      .i_a  (a_sr[0]),
      .i_b  (b_sr[0]),
      .i_bi (borrow),
      .o_d  (fs_d),
      .o_bo (fs_bo)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register here sees the pre-edge values of the others.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: the operand/result shift registers are reset too, so an
         // aborted operation leaves no stale bits behind.
         state  <= ST_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         d_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
         o_d    <= '0;
         o_bo   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  a_sr   <= i_a;
                  b_sr   <= i_b;
                  borrow <= 1'b0;
                  cnt    <= '0;
                  o_busy <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               d_sr   <= {fs_d, d_sr[WIDTH-1:1]};
               borrow <= fs_bo;
               if (cnt == LAST_BIT) begin
                  // Last bit: publish the full result in the same edge.
                  o_d    <= {fs_d, d_sr[WIDTH-1:1]};
                  o_bo   <= fs_bo;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               o_busy <= 1'b0;
               o_done <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start4, start8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       busy4, done4, bo4;
   logic       busy8, done8, bo8;
   logic [3:0] d4;
   logic [7:0] d8;

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start4),
      .i_a     (a4),
      .i_b     (b4),
      .o_busy  (busy4),
      .o_done  (done4),
      .o_d     (d4),
      .o_bo    (bo4)
   );

   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start8),
      .i_a     (a8),
      .i_b     (b8),
      .o_busy  (busy8),
      .o_done  (done8),
      .o_d     (d8),
      .o_bo    (bo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full 4-bit operation with cycle-exact busy/done checks. With b2b set the
   // caller is already in the DONE cycle and the start is staged right here.
   task automatic op4(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] ed, input logic ebo,
                      input bit b2b, input string name);
      if (!b2b) @(negedge clk);
      start4 = 1'b1;
      a4 = a;
      b4 = b;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         n_cmp++;
         if ({busy4, done4} !== 2'b10) begin
            n_err++;
            $display("FAIL %s run%0d busy/done: got %b expected 10", name, i, {busy4, done4});
         end
      end
      @(negedge clk);
      n_cmp++;
      if ({busy4, done4, d4, bo4} !== {2'b01, ed, ebo}) begin
         n_err++;
         $display("FAIL %s done: got busy=%b done=%b d=%0d bo=%b expected busy=0 done=1 d=%0d bo=%b",
                  name, busy4, done4, d4, bo4, ed, ebo);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input string name);
      logic [8:0] ref_diff;
      int k;
      ref_diff = {1'b0, a} - {1'b0, b};
      @(negedge clk);
      start8 = 1'b1;
      a8 = a;
      b8 = b;
      @(negedge clk);
      start8 = 1'b0;
      k = 0;
      while (done8 !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (done8 !== 1'b1 || k != 8) begin
         n_err++;
         $display("FAIL %s latency: got done after %0d cycles expected 8", name, k);
      end else begin
         n_cmp++;
         if ({d8, bo8} !== {ref_diff[7:0], ref_diff[8]}) begin
            n_err++;
            $display("FAIL %s result: got d=%0d bo=%b expected d=%0d bo=%b",
                     name, d8, bo8, ref_diff[7:0], ref_diff[8]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start4 = 1'b0; start8 = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy4, done4, d4, bo4, busy8, done8, d8, bo8} !== '0) begin
         n_err++;
         $display("FAIL reset outputs: got w4=%b_%b_%h_%b w8=%b_%b_%h_%b expected all zero",
                  busy4, done4, d4, bo4, busy8, done8, d8, bo8);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [3:0] va [4] = '{4'd7, 4'd3, 4'd0, 4'd15};
      logic [3:0] vb [4] = '{4'd3, 4'd7, 4'd0, 4'd1};
      logic [3:0] vd [4] = '{4'd4, 4'd12, 4'd0, 4'd14};
      logic       vbo[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         op4(va[i], vb[i], vd[i], vbo[i], 1'b0, $sformatf("basic%0d", i));
         @(negedge clk);
         n_cmp++;
         if ({busy4, done4, d4, bo4} !== {2'b00, vd[i], vbo[i]}) begin
            n_err++;
            $display("FAIL basic%0d hold: got busy=%b done=%b d=%0d bo=%b expected 0 0 %0d %b",
                     i, busy4, done4, d4, bo4, vd[i], vbo[i]);
         end
      end
   endtask

   task automatic test_start_held();
      @(negedge clk);
      start4 = 1'b1;
      a4 = 4'd10;
      b4 = 4'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a4 = 4'($urandom_range(0, 15));
         b4 = 4'($urandom_range(0, 15));
         n_cmp++;
         if ({busy4, done4} !== 2'b10) begin
            n_err++;
            $display("FAIL held run%0d busy/done: got %b expected 10", i, {busy4, done4});
         end
      end
      @(negedge clk);
      start4 = 1'b0;
      n_cmp++;
      if ({done4, d4, bo4} !== {1'b1, 4'd6, 1'b0}) begin
         n_err++;
         $display("FAIL held done: got done=%b d=%0d bo=%b expected 1 6 0", done4, d4, bo4);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy4, done4} !== 2'b00) begin
            n_err++;
            $display("FAIL held idle%0d busy/done: got %b expected 00", i, {busy4, done4});
         end
      end
   endtask

   task automatic test_back_to_back();
      op4(4'd6, 4'd1, 4'd5, 1'b0, 1'b0, "b2b_first");
      op4(4'd9, 4'd2, 4'd7, 1'b0, 1'b1, "b2b_second");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start4 = 1'b1;
      a4 = 4'd8;
      b4 = 4'd3;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy4, done4, d4, bo4} !== '0) begin
         n_err++;
         $display("FAIL midreset outputs: got busy=%b done=%b d=%0d bo=%b expected all zero",
                  busy4, done4, d4, bo4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy4, done4, d4, bo4} !== '0) begin
            n_err++;
            $display("FAIL midreset quiet%0d: got busy=%b done=%b d=%0d bo=%b expected all zero",
                     i, busy4, done4, d4, bo4);
         end
      end
      op4(4'd5, 4'd6, 4'd15, 1'b1, 1'b0, "after_reset");
   endtask

   task automatic test_sweep();
      logic [3:0] ra, rb;
      logic [4:0] rd;
      op8(8'd0, 8'd1, "w8_edge_lo");
      op8(8'd255, 8'd0, "w8_edge_hi");
      op8(8'd128, 8'd128, "w8_equal");
      for (int i = 0; i < 12; i++) begin
         op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $sformatf("w8_rand%0d", i));
      end
      for (int i = 0; i < 12; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         rd = {1'b0, ra} - {1'b0, rb};
         op4(ra, rb, rd[3:0], rd[4], 1'b0, $sformatf("w4_rand%0d", i));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_start_held();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_serial_subtractor
